comp_stats: RTL and testbench

- Registered statistics and lock-detect stage directly downstream of the 4-bit magnitude comparator.
- Samples each valid operand pair together with the comparator's agtb/altb/aeqb flags.
- Keeps saturating per-outcome event counters and a running maximum of a.
- Asserts a lock indication once LOCK_N consecutive valid samples compare equal.
- Feeds the lab's display/LED stage and self-checks the comparator flags for one-hot consistency.

---
 rtl/comp_stats.sv | 154 +++++++++++++++
 tb/tb_comp_stats.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/comp_stats.sv
// comp_stats: registered statistics and lock detector behind a 4-bit
// magnitude comparator. It counts gt/lt/eq outcomes with saturation and
// tracks the running maximum of operand a. It declares lock after LOCK_N
// consecutive equal samples, and latches an error when the comparator
// flags are not one-hot or disagree with the operands.
module comp_stats #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             agtb,
  input  logic             altb,
  input  logic             aeqb,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [3:0]       max_a,
  output logic             lock,
  output logic             out_valid,
  output logic             err
);

  // Streak target as a 4-bit constant; LOCK_N is limited to 1..15.
  localparam logic [3:0] LOCK_TGT = 4'(LOCK_N);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Flag vector order: [2]=gt, [1]=lt, [0]=eq. The counter generate loop
  // relies on this order too.
  logic [2:0]         w_flags;
  logic [2:0]         w_ref_flags;
  logic               w_onehot;
  logic               w_consistent;
  logic               w_accept;
  logic               w_reject;
  logic               w_wipe;
  logic [2:0]         w_hit;
  logic [3:0]         w_streak_next;
  state_t             w_state_next;
  logic [3*CNT_W-1:0] w_cnt_all;

  state_t     r_state;
  logic [3:0] r_streak;
  logic [3:0] r_max;
  logic       r_lock;
  logic       r_out_valid;
  logic       r_err;

  assign w_flags      = {agtb, altb, aeqb};
  assign w_ref_flags  = {(a > b), (a < b), (a == b)};
  assign w_onehot     = (w_flags == 3'b100) || (w_flags == 3'b010) ||
                        (w_flags == 3'b001);
  assign w_consistent = (w_flags == w_ref_flags);

  // rst and clear have the same effect on every register. The in_valid
  // sample of that cycle is dropped.
  assign w_wipe   = rst || clear;
  assign w_accept = in_valid && w_onehot && w_consistent;
  assign w_reject = in_valid && !(w_onehot && w_consistent);
  assign w_hit    = w_accept ? w_flags : 3'b000;

  // Per-outcome saturating event counters, one per flag
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gen_cnt
      logic [CNT_W-1:0] r_cnt;

      // Count accepted samples of this outcome and hold at all-ones
      always_ff @(posedge clk) begin
        if (w_wipe) begin
          r_cnt <= '0;
        end else if (w_hit[gi] && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_cnt_all[gi*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

  // Next equal-streak value. Eq samples count up to the lock target and
  // then hold. Gt/lt samples and rejected samples break the streak.
  // Idle cycles leave it alone.
  always_comb begin
    w_streak_next = r_streak;
    if (w_accept) begin
      if (aeqb) begin
        w_streak_next = (r_streak >= LOCK_TGT) ? LOCK_TGT : (r_streak + 4'd1);
      end else begin
        w_streak_next = 4'd0;
      end
    end else if (w_reject) begin
      w_streak_next = 4'd0;
    end
  end

  // Next FSM state. Any processed sample leaves IDLE. Reaching the streak
  // target locks, and anything that breaks the streak falls back to TRACK.
  always_comb begin
    w_state_next = r_state;
    if (w_accept && aeqb && (w_streak_next == LOCK_TGT)) begin
      w_state_next = ST_LOCKED;
    end else if (w_accept || w_reject) begin
      case (r_state)
        ST_IDLE:   w_state_next = ST_TRACK;
        ST_TRACK:  w_state_next = ST_TRACK;
        ST_LOCKED: w_state_next = ST_TRACK;
        default:   w_state_next = ST_TRACK;
      endcase
    end
  end

  // State, streak and all registered status outputs. lock is decoded from
  // the next state, so it rises together with out_valid for the sample that
  // completes the streak.
  always_ff @(posedge clk) begin
    if (w_wipe) begin
      r_state     <= ST_IDLE;
      r_streak    <= 4'd0;
      r_max       <= 4'd0;
      r_lock      <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_streak    <= w_streak_next;
      r_lock      <= (w_state_next == ST_LOCKED);
      r_out_valid <= in_valid;
      if (w_accept && (a > r_max)) begin
        r_max <= a;
      end
      if (w_reject) begin
        r_err <= 1'b1;
      end
    end
  end

  assign gt_cnt    = w_cnt_all[2*CNT_W +: CNT_W];
  assign lt_cnt    = w_cnt_all[1*CNT_W +: CNT_W];
  assign eq_cnt    = w_cnt_all[0*CNT_W +: CNT_W];
  assign max_a     = r_max;
  assign lock      = r_lock;
  assign out_valid = r_out_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_comp_stats.sv
// Self-checking bench for comp_stats. It runs directed scenarios and then
// randomized traffic against a behavioural model of the statistics.
module tb_comp_stats;

  localparam int CNT_W  = 2;
  localparam int LOCK_N = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [3:0]       a = 4'd0;
  logic [3:0]       b = 4'd0;
  logic             agtb = 1'b0;
  logic             altb = 1'b0;
  logic             aeqb = 1'b0;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [3:0]       max_a;
  logic             lock;
  logic             out_valid;
  logic             err;

  comp_stats #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .a(a), .b(b), .agtb(agtb), .altb(altb), .aeqb(aeqb),
    .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .max_a(max_a),
    .lock(lock), .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int step_no  = 0;

  // Reference model state: plain integers and a lock flag
  int m_gt, m_lt, m_eq, m_max, m_run;
  bit m_locked, m_err, m_ov;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL step %0d %s: got %0d expected %0d", step_no, tag, got, exp);
    end
  endtask

  // Flags a correct comparator would produce: {gt, lt, eq}
  function automatic logic [2:0] true_flags(input int x, input int y);
    if (x > y) return 3'b100;
    if (x < y) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : CNT_MAX;
  endfunction

  task automatic model_update(input bit r, input bit c, input bit v,
                              input int x, input int y, input logic [2:0] fl);
    if (r || c) begin
      m_gt = 0; m_lt = 0; m_eq = 0; m_max = 0; m_run = 0;
      m_locked = 0; m_err = 0; m_ov = 0;
    end else if (!v) begin
      m_ov = 0;
    end else begin
      m_ov = 1;
      if (fl == true_flags(x, y)) begin
        if (x > m_max) m_max = x;
        if (x > y) begin
          m_gt = sat_inc(m_gt); m_run = 0; m_locked = 0;
        end else if (x < y) begin
          m_lt = sat_inc(m_lt); m_run = 0; m_locked = 0;
        end else begin
          m_eq = sat_inc(m_eq);
          if (m_run < LOCK_N) m_run = m_run + 1;
          if (m_run == LOCK_N) m_locked = 1;
        end
      end else begin
        m_err = 1; m_run = 0; m_locked = 0;
      end
    end
  endtask

  task automatic check_all();
    check_val("gt_cnt", int'(gt_cnt), m_gt);
    check_val("lt_cnt", int'(lt_cnt), m_lt);
    check_val("eq_cnt", int'(eq_cnt), m_eq);
    check_val("max_a", int'(max_a), m_max);
    check_val("lock", int'(lock), int'(m_locked));
    check_val("out_valid", int'(out_valid), int'(m_ov));
    check_val("err", int'(err), int'(m_err));
  endtask

  // One clock: drive at the falling edge, check 1 ns after the rising edge
  task automatic step(input bit r, input bit c, input bit v,
                      input int x, input int y, input logic [2:0] fl);
    @(negedge clk);
    rst = r; clear = c; in_valid = v;
    a = 4'(x); b = 4'(y);
    {agtb, altb, aeqb} = fl;
    @(posedge clk);
    #1;
    step_no++;
    model_update(r, c, v, x, y, fl);
    check_all();
  endtask

  task automatic samp(input int x, input int y);
    step(0, 0, 1, x, y, true_flags(x, y));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 3'b000);
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 3'b000);
    step(1, 1, 1, 9, 9, 3'b001);

    // Single samples of each outcome
    samp(5, 3); idle(); samp(5, 7); idle(); samp(5, 5); idle();

    // Lock: eq, idle, eq, eq; then lt breaks it
    step(1, 0, 0, 0, 0, 3'b000);
    samp(9, 9); idle(); samp(9, 9); samp(2, 2); idle();
    samp(4, 6); idle();

    // Flag error, then soft clear
    samp(7, 7);
    step(0, 0, 1, 3, 8, 3'b100);
    idle();
    step(0, 1, 0, 0, 0, 3'b000);
    step(0, 0, 1, 4, 4, 3'b011);

    // Saturation and running maximum
    step(1, 0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 5; i++) samp(7, 1);
    samp(15, 0);

    // Priority: streak of 2, then rst and clear with an eq sample
    step(1, 0, 0, 0, 0, 3'b000);
    samp(6, 6); samp(6, 6);
    step(1, 1, 1, 6, 6, 3'b001);
    samp(6, 6);

    // Mid-lock idle
    samp(6, 6); samp(6, 6);
    for (int i = 0; i < 10; i++) idle();
    samp(6, 6);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, c, v;
      int x, y;
      logic [2:0] fl;
      r = ($urandom_range(0, 249) == 0);
      c = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 3) != 0);
      x = $urandom_range(0, 15);
      y = ($urandom_range(0, 9) < 4) ? x : $urandom_range(0, 15);
      fl = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7))
                                        : true_flags(x, y);
      step(r, c, v, x, y, fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
